// File: rtl/ifc_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package ifc_pkg;

  localparam int ADDR_W = 32;

  // Byte distance between consecutive instructions; the IF stage uses this
  // for PC+4 after a redirect target is captured.
  localparam logic [ADDR_W-1:0] INSTR_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } ifc_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, hazard/branch logic, IF stage
// and instruction memory.
//
// Memory handshake: imem_req is a level request. A transfer happens in any
// cycle where imem_req and imem_ack are both high. imem_ack while imem_req
// is low carries no meaning and is ignored. imem_req may drop without an
// ack (redirect or reset); the memory must tolerate an abandoned request.
interface if_fetch_ctrl_if;
  import ifc_pkg::*;

  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              imem_ack;
  logic              imem_req;
  logic              En;
  logic              Clr;
  logic              PCSrc;
  logic [ADDR_W-1:0] JumpAddr;
  logic              fetch_err;

  // Controller side
  modport master (
    input  stall, redir_valid, redir_target, imem_ack,
    output imem_req, En, Clr, PCSrc, JumpAddr, fetch_err
  );

  // Environment side (hazard unit, IF stage, memory)
  modport slave (
    output stall, redir_valid, redir_target, imem_ack,
    input  imem_req, En, Clr, PCSrc, JumpAddr, fetch_err
  );

endinterface

// File: rtl/ifc_timeout_cnt.sv
// Saturating counter of consecutive unacknowledged request cycles.
// o_expired flags the cycle that would take the count to MAX.
module ifc_timeout_cnt #(
  parameter  int MAX = 16,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic         o_expired,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  // Clear has priority over increment; count holds once it reaches MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry: already at MAX-1 and this cycle is unacknowledged again.
  always_comb begin
    o_expired = i_inc && !i_clr && (r_cnt == W'(MAX - 1));
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller: drives IF En/Clr/PCSrc/JumpAddr,
// runs the req/ack fetch handshake, holds a pending redirect until its fetch
// completes and latches a sticky timeout error.
// Optional macro IFC_PERF_EN adds perf_fetch/perf_wait/perf_flush counters.
module if_fetch_ctrl
  import ifc_pkg::*;
#(
  parameter  logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter  int                TIMEOUT      = 16,
  localparam int                TMO_W        = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  if_fetch_ctrl_if.master      bus,
  output ifc_state_e           o_dbg_state,
  output logic [TMO_W-1:0]     o_dbg_tmo
`ifdef IFC_PERF_EN
  ,
  output logic [31:0]          perf_fetch,
  output logic [31:0]          perf_wait,
  output logic [31:0]          perf_flush
`endif
);

  ifc_state_e        r_state;
  ifc_state_e        w_next_state;
  logic              r_pend;
  logic [ADDR_W-1:0] r_tgt;
  logic              w_req;
  logic              w_en;
  logic              w_clr;
  logic              w_pcsrc;
  logic              w_err;
  logic              w_xfer;
  logic              w_redir_acc;
  logic              w_tmo_clr;
  logic              w_tmo_inc;
  logic              w_expired;

  assign w_xfer      = w_req & bus.imem_ack;
  assign w_redir_acc = (r_state == FETCH) & bus.redir_valid;
  assign w_tmo_clr   = w_xfer | w_redir_acc | !w_req;
  assign w_tmo_inc   = w_req & !bus.imem_ack;

  ifc_timeout_cnt #(.MAX(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmo_clr),
    .i_inc     (w_tmo_inc),
    .o_expired (w_expired),
    .o_count   (o_dbg_tmo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOOT;
    else      r_state <= w_next_state;
  end

  // Next state: BOOT lasts one cycle, timeout traps into ERROR until reset.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      BOOT:    w_next_state = FETCH;
      FETCH:   if (w_expired) w_next_state = ERROR;
      ERROR:   w_next_state = ERROR;
      default: w_next_state = BOOT;
    endcase
  end

  // Outputs: redirect flushes first, then a completed fetch advances IF,
  // otherwise a bubble is inserted only when waiting on memory (not on stall).
  always_comb begin
    w_req   = 1'b0;
    w_en    = 1'b0;
    w_clr   = 1'b0;
    w_pcsrc = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      BOOT: begin
      end
      FETCH: begin
        w_req   = !bus.stall | r_pend;
        w_pcsrc = r_pend;
        if (bus.redir_valid)              w_clr = 1'b1;
        else if (w_req && bus.imem_ack)   w_en  = 1'b1;
        else if (!r_pend)                 w_clr = !bus.stall;
      end
      ERROR: begin
        w_clr = 1'b1;
        w_err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Pending redirect: the newest redirect wins; cleared when its fetch lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b1;
      r_tgt  <= RESET_VECTOR;
    end else if (w_redir_acc) begin
      r_pend <= 1'b1;
      r_tgt  <= bus.redir_target;
    end else if (r_pend && w_xfer) begin
      r_pend <= 1'b0;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.En        = w_en;
  assign bus.Clr       = w_clr;
  assign bus.PCSrc     = w_pcsrc;
  assign bus.JumpAddr  = r_tgt;
  assign bus.fetch_err = w_err;
  assign o_dbg_state   = r_state;

`ifdef IFC_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_wait;
  logic [31:0] r_perf_flush;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_wait  <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_en)        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_tmo_inc)   r_perf_wait  <= r_perf_wait  + 32'd1;
      if (w_redir_acc) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_wait  = r_perf_wait;
  assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus random
// traffic, checked against a behavioural model through an expected queue.
module tb_if_fetch_ctrl;
  import ifc_pkg::*;

  localparam int          TO = 16;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          EW = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_ctrl_if bus();
  ifc_state_e dbg_state;
  logic [4:0] dbg_tmo;
`ifdef IFC_PERF_EN
  logic [31:0] perf_fetch, perf_wait, perf_flush;
`endif

  if_fetch_ctrl #(.RESET_VECTOR(RV), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_tmo   (dbg_tmo)
`ifdef IFC_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_wait   (perf_wait),
    .perf_flush  (perf_flush)
`endif
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [1:0] st, input logic err,
      input logic req, input logic en, input logic clr, input logic pc,
      input logic [4:0] tmo, input logic [31:0] ja);
    return {st, err, req, en, clr, pc, tmo, ja};
  endfunction

  // Monitor: every clocked cycle out of reset, compare against the queue head.
  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      e = exp_q.pop_front();
      a = pack(dbg_state, bus.fetch_err, bus.imem_req, bus.En, bus.Clr,
               bus.PCSrc, dbg_tmo, bus.JumpAddr);
      check($sformatf("cycle%0d st/err/req/en/clr/pc/tmo/ja", cyc), 64'(a), 64'(e));
      cyc++;
    end
  end

  // ---------------- reference model ----------------
  bit          m_boot, m_err, m_pend;
  logic [31:0] m_tgt;
  int          m_wait;   // consecutive requested-but-unacked cycles

  task automatic model_reset();
    m_boot = 1; m_err = 0; m_pend = 1; m_tgt = RV; m_wait = 0;
  endtask

  // Apply one cycle of inputs, predict outputs, advance the model, step clock.
  task automatic drive_cycle(input bit st, input bit rv, input logic [31:0] tg, input bit ack);
    logic [1:0] e_st;
    bit e_err, e_req, e_en, e_clr, e_pc, xfer;
    logic [4:0] e_tmo;
    logic [31:0] e_ja;
    bus.stall = st; bus.redir_valid = rv; bus.redir_target = tg; bus.imem_ack = ack;
    e_err = 0; e_req = 0; e_en = 0; e_clr = 0; e_pc = 0;
    e_ja  = m_tgt;
    e_tmo = 5'(m_wait);
    if (m_boot) begin
      e_st = BOOT; m_boot = 0; m_wait = 0;
    end else if (m_err) begin
      e_st = ERROR; e_clr = 1; e_err = 1; m_wait = 0;
    end else begin
      e_st  = FETCH;
      e_req = !st || m_pend;
      e_pc  = m_pend;
      xfer  = e_req && ack;
      if (rv) begin
        e_clr = 1; m_pend = 1; m_tgt = tg; m_wait = 0;
      end else begin
        if (xfer) begin
          e_en = 1; m_pend = 0;
        end else if (!m_pend) begin
          e_clr = !st;
        end
        if (e_req && !ack) begin
          m_wait++;
          if (m_wait == TO) m_err = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
    exp_q.push_back(pack(e_st, e_err, e_req, e_en, e_clr, e_pc, e_tmo, e_ja));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " req"},   64'(bus.imem_req),  64'(0));
    check({tag, " En"},    64'(bus.En),        64'(0));
    check({tag, " Clr"},   64'(bus.Clr),       64'(0));
    check({tag, " PCSrc"}, 64'(bus.PCSrc),     64'(0));
    check({tag, " err"},   64'(bus.fetch_err), 64'(0));
    check({tag, " JA"},    64'(bus.JumpAddr),  64'(RV));
    check({tag, " state"}, 64'(dbg_state),     64'(BOOT));
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_reset(tag);
    bus.stall = 0; bus.redir_valid = 0; bus.redir_target = '0; bus.imem_ack = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.stall = 0; bus.redir_valid = 0; bus.redir_target = '0; bus.imem_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;

    // Zero-wait memory, no stall.
    for (int i = 0; i < 8; i++) drive_cycle(0, 0, '0, 1);

    // Memory acks every third cycle.
    for (int i = 0; i < 9; i++) drive_cycle(0, 0, '0, (i % 3) == 2);

    // Redirect to 0x40 while a fetch is outstanding, ack in the same cycle.
    drive_cycle(0, 0, '0, 0);
    drive_cycle(0, 1, 32'h40, 1);
    drive_cycle(0, 0, '0, 0);
    drive_cycle(0, 0, '0, 0);
    drive_cycle(0, 0, '0, 1);
    drive_cycle(0, 0, '0, 1);

    // Back-to-back redirects, ack low: the later target must win.
    drive_cycle(0, 1, 32'h80, 0);
    drive_cycle(0, 1, 32'hC0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, '0, 0);
    drive_cycle(0, 0, '0, 1);

    // Stall with nothing pending: no request, no bubble, counter idle.
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, '0, 0);
    drive_cycle(0, 0, '0, 1);
    drive_cycle(0, 0, '0, 1);

    // Stalled redirect: still taken, and the pending fetch ignores stall.
    drive_cycle(1, 1, 32'h100, 0);
    drive_cycle(1, 0, '0, 0);
    drive_cycle(1, 0, '0, 1);
    drive_cycle(1, 0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
    end

    // Reset with a redirect outstanding.
    drive_cycle(0, 1, 32'h200, 0);
    drive_cycle(0, 0, '0, 0);
    do_reset("midfetch reset");
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, '0, 1);

    // Timeout: sixteen unacked request cycles, then sticky error.
    for (int i = 0; i < TO; i++) drive_cycle(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(i[0], 1, 32'h300, 1);
    do_reset("error reset");
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, '0, 1);

    @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
